// File: rtl/xarb_pkg.sv
// Shared types and helpers for the two-requester arbitrated result slot.
// Holds the default widths, the slot state encoding and the result bit format.
package xarb_pkg;

    localparam int DW_DEF = 4;
    localparam int CW_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Result format: every odd bit carries the AND-reduction, every even bit is zero.
    function automatic logic fmt_bit(input logic r, input int idx);
        return r && (idx % 2 == 1);
    endfunction

endpackage

// File: rtl/xarb_rr2.sv
// Two-way round-robin grant. The pointer remembers the last granted requester
// and moves only when the caller reports an accepted transfer.
module xarb_rr2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_p1;

    // Reset value 1 makes requester 0 win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_p1 <= 1'b1;
        else if (advance)
            last_p1 <= gnt[1];
    end

    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = last_p1 ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/xarb_ctrl.sv
// Arbitrated single-entry result slot: two requesters compete for one
// registered result; each accepted operand is reduced, formatted and counted.
module xarb_ctrl
    import xarb_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a0_valid,
    input  logic [DW-1:0] a0,
    output logic          a0_ready,
    input  logic          a1_valid,
    input  logic [DW-1:0] a1,
    output logic          a1_ready,
    output logic [DW-1:0] reg_out,
    output logic          res_valid,
    output logic          res_id,
    input  logic          res_ready,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    logic [1:0]    req;
    logic [1:0]    gnt;
    logic [1:0]    rdy;
    logic          slot_free;
    logic          accept;
    state_t        state_p1;
    state_t        state_nxt;
    logic [DW-1:0] opnd;
    logic [DW-1:0] fmt_data;
    logic [DW-1:0] data_p1;
    logic          id_p1;
    logic [CW-1:0] cnt0_p1;
    logic [CW-1:0] cnt1_p1;

    assign req = {a1_valid, a0_valid};

    xarb_rr2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (accept),
        .gnt     (gnt)
    );

    // Ready depends only on registered state, requester valids and res_ready.
    always_comb begin
        state_nxt = state_p1;
        slot_free = (state_p1 == IDLE) || res_ready;
        rdy       = gnt & {2{slot_free & rst_n}};
        accept    = |rdy;
        if (accept)
            state_nxt = HOLD;
        else if (res_ready)
            state_nxt = IDLE;
    end

    always_comb begin
        opnd = gnt[1] ? a1 : a0;
        for (int i = 0; i < DW; i++)
            fmt_data[i] = fmt_bit(&opnd, i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_p1 <= IDLE;
        else
            state_p1 <= state_nxt;
    end

    // ---- result / count stage (p1) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p1 <= '0;
            id_p1   <= 1'b0;
            cnt0_p1 <= '0;
            cnt1_p1 <= '0;
        end else if (accept) begin
            data_p1 <= fmt_data;
            id_p1   <= gnt[1];
            if (gnt[1])
                cnt1_p1 <= cnt1_p1 + CW'(1);
            else
                cnt0_p1 <= cnt0_p1 + CW'(1);
        end
    end

    assign a0_ready  = rdy[0];
    assign a1_ready  = rdy[1];
    assign reg_out   = data_p1;
    assign res_valid = (state_p1 == HOLD);
    assign res_id    = id_p1;
    assign cnt0      = cnt0_p1;
    assign cnt1      = cnt1_p1;

endmodule
